traffic_phase_timer: RTL and testbench
======================================

// Module: traffic_phase_timer
// PURPOSE
//  Phase-duration timer that sits upstream of the traffic light controller.
//  Divides clk into a 1 s tick and counts down the dwell time of the requested phase (RED/GREEN/YELLOW).
//  Raises a one-cycle done pulse that the controller uses to advance its lights[2:0] sequence.
//  Adds hold (freeze) and restart semantics so the controller stays a pure sequencer.
// PARAMETERS
//  TICK_DIV   100_000_000  clk cycles per tick (1 s at 100 MHz); >= 2
//  CNT_W      8            width of the seconds counter / remaining output
//  RED_T      12           RED dwell, in ticks
//  GREEN_T    10           GREEN dwell, in ticks
//  YELLOW_T   3            YELLOW dwell, in ticks
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous reset, ACTIVE-LOW (0 = reset)
//  start      in   1       load the duration of phase and begin counting; sampled each clk edge
//  phase      in   2       0=RED, 1=GREEN, 2=YELLOW, 3=illegal (timed as RED)
//  hold       in   1       freeze prescaler and countdown while high
//  busy       out  1       countdown in progress
//  done       out  1       one-cycle pulse: dwell expired
//  remaining  out  CNT_W   whole ticks left in the current dwell
//  tick       out  1       one-cycle pulse per prescaler wrap (debug/bench)
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, prescaler=0, remaining=0, busy=0, done=0, tick=0.
//  - All outputs are registered.
//  - FSM states: IDLE, RUN.
//    - IDLE --start--> RUN: remaining<=dur(phase), prescaler<=0, busy<=1.
//    - RUN: prescaler increments when hold==0. At TICK_DIV-1 it wraps to 0 and tick<=1 for one cycle.
//    - RUN, tick with remaining>1: remaining<=remaining-1.
//    - RUN, tick with remaining==1: remaining<=0, busy<=0, done<=1 (one cycle), go to IDLE.
//  - Latency: start sampled at edge 0 -> done high during the cycle after edge D*TICK_DIV, where D=dur(phase).
//    This assumes no hold; each hold-high cycle extends the latency by one cycle.
//  - hold==1: prescaler, remaining and state frozen; tick stays 0. start still acts (see below).
//  - start while RUN: restart. Reload from the new phase, clear the prescaler, no done for the aborted dwell.
//  - start on the same edge as the final tick: start wins. Reload, done stays 0.
//  - dur(phase)==0 (parameter set to 0): enter RUN and expire on the next edge. done pulses one cycle after start.
//  - phase==3: timed with RED_T (fail-safe; RED is the safe aspect).
//  - Durations wider than CNT_W are truncated. The package provides a width check; elaboration error if violated.
//  - Reset asserted mid-dwell: everything returns to reset values immediately; no done is produced.
//  - done and tick never assert while reset==0.
// STRUCTURE
//  - Shared package traffic_pkg:
//    - phase encodings PH_RED/PH_GREEN/PH_YELLOW (2-bit);
//    - FSM state encoding;
//    - duration-select function dur(phase).
//  - Sub-module tick_prescaler(clk, reset, en, clr, tick):
//    - counter 0..TICK_DIV-1, $clog2(TICK_DIV) bits;
//    - clr has priority over en;
//    - reused later by the pedestrian-request debouncer.
//  - Top level holds the FSM, the remaining counter and the done register.
// TESTING  (bench overrides TICK_DIV=4; RED_T=3, GREEN_T=2, YELLOW_T=1)
//  1. Reset low 20 ns then high -> busy=0, done=0, remaining=0, tick=0; no tick while IDLE.
//  2. start=1 one cycle, phase=1 -> remaining=2, busy=1; done pulses one cycle 8 clk later; busy=0, remaining=0.
//  3. phase=2 run with hold=1 for 5 cycles mid-dwell -> remaining frozen, done delayed by exactly 5 cycles (4+5).
//  4. phase=0 running, start phase=2 at remaining=2 -> remaining=1, no done for RED; done 4 clk after restart.
//  5. start coincident with final tick of phase=1 -> done stays 0; remaining reloads to new dur; busy stays 1.
//  6. Drop reset for 1 cycle mid-dwell of phase=3 -> outputs cleared async; no done; phase=3 earlier gives remaining=3.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase timer: phase codes, FSM states
// and the duration-select helpers used by the timer top level.
package traffic_pkg;

  localparam logic [1:0] PH_RED    = 2'd0;
  localparam logic [1:0] PH_GREEN  = 2'd1;
  localparam logic [1:0] PH_YELLOW = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Code 3 is not a real phase; it falls back to RED because RED is the safe aspect.
  function automatic int unsigned dur(input logic [1:0] phase,
                                      input int unsigned redT,
                                      input int unsigned greenT,
                                      input int unsigned yellowT);
    case (phase)
      PH_GREEN:  dur = greenT;
      PH_YELLOW: dur = yellowT;
      default:   dur = redT;
    endcase
  endfunction

  function automatic bit durFits(input int unsigned value, input int unsigned width);
    if (width >= 32) return 1'b1;
    return (value >> width) == 0;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider: counts 0..TICK_DIV-1 while enabled and emits a
// registered one-cycle tick on each wrap; clr has priority over en.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic wrap
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_count;
  logic          r_tick;

  // Combinational wrap lets the owner act on the same edge the tick register sets.
  assign wrap = en && !clr && (r_count == CW'(TICK_DIV - 1));
  assign tick = r_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (en) begin
      r_count <= wrap ? '0 : r_count + 1'b1;
      r_tick  <= wrap;
    end else begin
      r_tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase dwell timer: loads the duration of the requested phase, counts it down
// in prescaler ticks and pulses done when it expires; supports hold and restart.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned RED_T    = 12,
  parameter int unsigned GREEN_T  = 10,
  parameter int unsigned YELLOW_T = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       phase,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic             tick
);

  if (!durFits(RED_T, CNT_W) || !durFits(GREEN_T, CNT_W) || !durFits(YELLOW_T, CNT_W)) begin : g_widthCheck
    $error("traffic_phase_timer: a phase duration does not fit in CNT_W bits");
  end

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_remNext;
  logic             r_busy;
  logic             w_busyNext;
  logic             r_done;
  logic             w_doneNext;
  logic [CNT_W-1:0] w_dur;
  logic             w_en;
  logic             w_clr;
  logic             w_wrap;

  assign w_dur = CNT_W'(dur(phase, RED_T, GREEN_T, YELLOW_T));
  assign w_en  = (r_state == ST_RUN) && !hold;
  // Keeping the prescaler cleared while idle makes every dwell start from a fresh count.
  assign w_clr = start || (r_state != ST_RUN);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (w_en),
    .clr  (w_clr),
    .tick (tick),
    .wrap (w_wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_remaining <= w_remNext;
      r_busy      <= w_busyNext;
      r_done      <= w_doneNext;
    end
  end

  // Start overrides everything, including an expiry landing on the same edge.
  always_comb begin
    w_stateNext = r_state;
    w_remNext   = r_remaining;
    w_busyNext  = r_busy;
    w_doneNext  = 1'b0;
    if (start) begin
      w_stateNext = ST_RUN;
      w_remNext   = w_dur;
      w_busyNext  = 1'b1;
    end else if (r_state == ST_RUN) begin
      if (r_remaining == '0 || (w_wrap && r_remaining == CNT_W'(1))) begin
        w_stateNext = ST_IDLE;
        w_remNext   = '0;
        w_busyNext  = 1'b0;
        w_doneNext  = 1'b1;
      end else if (w_wrap) begin
        w_remNext   = r_remaining - 1'b1;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign remaining = r_remaining;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer with a fast prescaler (TICK_DIV=4)
// and short dwells (RED=3, GREEN=2, YELLOW=1 ticks).
module tb_traffic_phase_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] phase = 2'd0;
  logic       hold = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] remaining;
  logic       tick;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic       start;
    logic [1:0] phase;
    logic       hold;
    logic       expBusy;
    logic       expDone;
    logic [7:0] expRem;
    logic       expTick;
  } vec_t;

  vec_t vecs[13];

  traffic_phase_timer #(
    .TICK_DIV(4),
    .CNT_W   (8),
    .RED_T   (3),
    .GREEN_T (2),
    .YELLOW_T(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .phase    (phase),
    .hold     (hold),
    .busy     (busy),
    .done     (done),
    .remaining(remaining),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] p, input logic h);
    start = s;
    phase = p;
    hold  = h;
  endtask

  task automatic checkOutput(input string name, input logic eBusy, input logic eDone,
                             input logic [7:0] eRem, input logic eTick);
    compared++;
    if ({busy, done, remaining, tick} !== {eBusy, eDone, eRem, eTick}) begin
      mismatched++;
      $display("[TB] FAIL %s: got busy=%b done=%b remaining=%0d tick=%b, want busy=%b done=%b remaining=%0d tick=%b",
               name, busy, done, remaining, tick, eBusy, eDone, eRem, eTick);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Returns the number of cycles until done is seen, or -1 if the budget runs out.
  task automatic waitDone(input int maxCycles, output int n);
    bit found = 1'b0;
    n = -1;
    for (int i = 1; i <= maxCycles && !found; i++) begin
      stepCycle();
      if (done === 1'b1) begin
        n = i;
        found = 1'b1;
      end
    end
  endtask

  initial begin
    int n;
    int badCount;

    vecs[0]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[3]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0};
    vecs[11] = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1};
    vecs[12] = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};

    // Reset low for ~20 ns
    #1 reset = 1'b0;
    #2 checkOutput("resetState", 1'b0, 1'b0, 8'd0, 1'b0);
    #17 reset = 1'b1;

    // Idle cycles then a full GREEN dwell, cycle by cycle
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].start, vecs[i].phase, vecs[i].hold);
      stepCycle();
      checkOutput($sformatf("vec%0d", i), vecs[i].expBusy, vecs[i].expDone,
                  vecs[i].expRem, vecs[i].expTick);
    end
    applyStimulus(1'b0, 2'd0, 1'b0);

    // YELLOW with a 5-cycle hold mid-dwell
    applyStimulus(1'b1, 2'd2, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 2'd2, 1'b0);
    checkOutput("holdLoad", 1'b1, 1'b0, 8'd1, 1'b0);
    stepCycle();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput($sformatf("holdFrozen%0d", i), 1'b1, 1'b0, 8'd1, 1'b0);
    end
    hold = 1'b0;
    waitDone(20, n);
    checkValue("holdDoneDelay", n, 3);
    stepCycle();
    checkOutput("holdAfterDone", 1'b0, 1'b0, 8'd0, 1'b0);

    // RED restarted as YELLOW at remaining=2
    applyStimulus(1'b1, 2'd0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 1'b0);
    checkOutput("redLoad", 1'b1, 1'b0, 8'd3, 1'b0);
    repeat (5) stepCycle();
    checkOutput("redAtTwo", 1'b1, 1'b0, 8'd2, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 2'd2, 1'b0);
    checkOutput("restartLoad", 1'b1, 1'b0, 8'd1, 1'b0);
    waitDone(20, n);
    checkValue("restartDoneDelay", n, 4);
    stepCycle();

    // Start coincident with the final tick of GREEN
    applyStimulus(1'b1, 2'd1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 2'd1, 1'b0);
    repeat (7) stepCycle();
    checkOutput("finalTickBefore", 1'b1, 1'b0, 8'd1, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 1'b0);
    checkOutput("startWinsFinal", 1'b1, 1'b0, 8'd3, 1'b0);
    waitDone(40, n);
    checkValue("startWinsDoneDelay", n, 12);
    stepCycle();

    // Illegal phase timed as RED, then reset dropped mid-dwell
    applyStimulus(1'b1, 2'd3, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 2'd3, 1'b0);
    checkOutput("illegalAsRed", 1'b1, 1'b0, 8'd3, 1'b0);
    repeat (4) stepCycle();
    checkOutput("illegalAfterTick", 1'b1, 1'b0, 8'd2, 1'b1);
    reset = 1'b0;
    #1 checkOutput("asyncResetClear", 1'b0, 1'b0, 8'd0, 1'b0);
    stepCycle();
    checkOutput("resetHeld", 1'b0, 1'b0, 8'd0, 1'b0);
    reset = 1'b1;
    badCount = 0;
    for (int i = 0; i < 16; i++) begin
      stepCycle();
      if (done !== 1'b0 || busy !== 1'b0 || remaining !== 8'd0) badCount++;
    end
    checkValue("noDoneAfterReset", badCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
